run_counter: RTL and testbench
==============================

Name: run_counter

Overview:
- Free-running, wrap-around binary up-counter of configurable width.
- Has a synchronous clear, a count enable, and a registered "running" status flag.
- Used as a generic timing/sequencing primitive (e.g. bit-timing and slot counters) inside larger protocol controllers.

Parameters:
- CW, 3, counter width in bits (legal range 1..32).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately, rst=1 releases.
- ena  input  1  count enable, synchronous.
- clr  input  1  synchronous clear; has priority over ena.
- cnt  output CW  current counter value, registered.
- out  output 1  running status, registered.

Behaviour:
- Reset (rst=0): cnt=0 and out=0 asynchronously, regardless of clk, ena or clr. Both are held while rst=0.
- Reset release: the first rising edge with rst=1 evaluates the normal rules. No extra synchroniser inside the block; the caller guarantees release timing.
- Per rising edge, with rst=1, priority order:
  - clr=1: cnt <= 0, out <= 0 (ena ignored).
  - clr=0, ena=1: cnt <= cnt+1 modulo 2^CW, out <= 1.
  - clr=0, ena=0: cnt holds, out <= 0.
- out is a registered flag. It is 1 in exactly the cycles following an edge on which the counter advanced.
- Latency: one cycle from ena/clr sampled at an edge to cnt/out update. No combinational path from inputs to outputs.
- Wrap-around: from 2^CW-1 with ena=1, clr=0, cnt goes to 0 and out stays 1. No saturation and no wrap flag.
- Simultaneous clr=1 and ena=1: clear wins; cnt=0, out=0.
- clr held for several cycles: cnt stays 0 and out stays 0 for the whole duration.
- clr deasserted with ena=1: the counter resumes 1, 2, … starting on the first edge with clr=0.
- Reset mid-count: cnt and out go to 0 immediately (asynchronously). Counting restarts from 0 after release.
- X/Z on ena or clr while rst=1 is illegal; no defined behaviour is required.

Decomposition:
- No shared package needed. CW is the only configuration item and stays a module parameter.
- No sub-modules: a single flat module with one always block for cnt and out, both using the async-low reset.

Test Plan (CW=3, clk period 20 ns):
- Reset hold: rst=0 for 2 edges with ena=0, clr=0 -> cnt=0, out=0. Also assert rst=0 between edges -> outputs go to 0 without waiting for an edge.
- Idle after release: rst=1, ena=0, clr=0 for 2 edges -> cnt stays 0, out stays 0.
- Count and wrap: ena=1 for 8 edges -> cnt sequence 1,2,3,4,5,6,7,0; out=1 after the first enabled edge and stays 1 through the wrap.
- Clear priority: ena=1, clr=1 for 4 edges from a non-zero value -> cnt=0 and out=0 after the first edge, held for all 4 edges.
- Resume: clr=0, ena=1 for 8 edges -> cnt 1..7,0; then ena=0 -> cnt holds its value and out=0 one cycle later.
- Async reset mid-count: pull rst=0 while cnt=5 between clock edges -> cnt=0, out=0 immediately. After release with ena=1, counting restarts at 1.

Source files
------------

// File: rtl/run_counter.sv
// Free-running wrap-around up-counter with synchronous clear, count enable
// and a registered flag marking cycles that follow an advancing edge.
module run_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          out
);

  logic [CW-1:0] r_cnt;
  logic          r_out;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values. Both flops clear asynchronously on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (ena) begin
      r_cnt <= r_cnt + CW'(1);
      r_out <= 1'b1;
    end else begin
      r_out <= 1'b0;
    end
  end

  assign cnt = r_cnt;
  assign out = r_out;

endmodule

// File: tb/tb_run_counter.sv
// Self-checking bench for run_counter: directed vector table, hand-written
// async-reset sequences, and randomized stimulus against a reference model.
module tb_run_counter;

  localparam int CW  = 3;
  localparam int MOD = 1 << CW;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          clr;
  logic [CW-1:0] cnt;
  logic          out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          ena;
    logic          clr;
    logic [CW-1:0] exp_cnt;
    logic          exp_out;
  } vec_t;

  vec_t vecs[$];

  run_counter #(.CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .clr (clr),
    .cnt (cnt),
    .out (out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Apply inputs, wait for one rising edge, sample 1 ns later.
  task automatic step(input logic e, input logic c);
    ena = e;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic e, input logic c, input int ec, input logic eo);
    vec_t v;
    v.ena     = e;
    v.clr     = c;
    v.exp_cnt = CW'(ec);
    v.exp_out = eo;
    vecs.push_back(v);
  endtask

  initial begin
    int m_cnt;
    int m_out;

    // Idle after release
    push(0, 0, 0, 0);
    push(0, 0, 0, 0);
    // Count and wrap
    for (int i = 1; i <= 8; i++) push(1, 0, i % MOD, 1);
    // Advance to a non-zero value, then clear with ena also high
    push(1, 0, 1, 1);
    for (int i = 0; i < 4; i++) push(1, 1, 0, 0);
    // Resume after clear, through the wrap
    for (int i = 1; i <= 8; i++) push(1, 0, i % MOD, 1);
    // Count to 2, then hold
    push(1, 0, 1, 1);
    push(1, 0, 2, 1);
    push(0, 0, 2, 0);
    push(0, 0, 2, 0);

    rst = 1'b1;
    ena = 1'b0;
    clr = 1'b0;

    // Reset asserted between edges must act without a clock edge
    #5 rst = 1'b0;
    #1;
    check("async_rst_cnt_t0", int'(cnt), 0);
    check("async_rst_out_t0", int'(out), 0);

    // Reset hold across two edges
    step(0, 0);
    step(0, 0);
    check("rst_hold_cnt", int'(cnt), 0);
    check("rst_hold_out", int'(out), 0);
    #4 rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ena, vecs[i].clr);
      check($sformatf("vec%0d_cnt", i), int'(cnt), int'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].exp_out));
    end

    // Count from 2 up to 5, then reset between edges
    step(1, 0);
    step(1, 0);
    step(1, 0);
    check("pre_rst_cnt", int'(cnt), 5);
    #4 rst = 1'b0;
    #1;
    check("mid_rst_cnt", int'(cnt), 0);
    check("mid_rst_out", int'(out), 0);
    step(1, 0);
    check("rst_held_cnt", int'(cnt), 0);
    check("rst_held_out", int'(out), 0);
    #4 rst = 1'b1;
    step(1, 0);
    check("restart_cnt1", int'(cnt), 1);
    check("restart_out1", int'(out), 1);
    step(1, 0);
    check("restart_cnt2", int'(cnt), 2);

    // Randomized stimulus against the behavioural model
    m_cnt = 2;
    m_out = 1;
    for (int i = 0; i < 300; i++) begin
      logic e;
      logic c;
      e = ($urandom % 4) != 0;
      c = ($urandom % 8) == 0;
      if (c) begin
        m_cnt = 0;
        m_out = 0;
      end else if (e) begin
        m_cnt = (m_cnt + 1) % MOD;
        m_out = 1;
      end else begin
        m_out = 0;
      end
      step(e, c);
      check($sformatf("rand%0d_cnt", i), int'(cnt), m_cnt);
      check($sformatf("rand%0d_out", i), int'(out), m_out);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
